mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 4, width of the bus-wait counter; the timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-002 The block SHALL have parameter RD_X0_GUARD, default 1; when 1, register writes to x0 are suppressed.
REQ-003 The block SHALL have one clock and a synchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous reset, active low.
REQ-004 instr  input  32  current instruction-register contents; opcode [6:0], rd [11:7], funct3 [14:12], funct7 [31:25].
REQ-005 im_ack  input  1  instruction-memory acknowledge; dm_ack  input  1  data-memory acknowledge; br_taken  input  1  branch comparator result.
REQ-006 im_req  output  1  fetch request; ir_en  output  1  instruction-register load strobe; pc_en  output  1  PC update strobe.
REQ-007 dm_req  output  1  data-memory request; dm_we  output  1  data-memory write enable; rf_en  output  1  register-file write enable.
REQ-008 sel_opr_a  output  1  (0 rs1, 1 PC); sel_opr_b  output  1  (0 rs2, 1 imm); sel_pc  output  1  (0 PC+4, 1 ALU result); sel_wb  output  2  (00 ALU, 01 memory, 10 PC+4).
REQ-009 imm_type  output  3  (000 I, 001 S, 010 B, 011 U, 100 J); aluop  output  4  ALU operation.
REQ-010 state  output  3  current FSM state; illegal  output  1  sticky illegal-instruction flag; bus_err  output  1  sticky bus-timeout flag.

Function
REQ-011 The FSM SHALL use states FETCH=000, DECODE=001, EXECUTE=010, MEM=011, WB=100, TRAP=111.
REQ-012 aluop encoding SHALL be: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001, pass-B 1010.
REQ-013 For R-type (0110011), the ALU operation SHALL decode from funct3/funct7; funct7=0100000 is valid only with funct3 000 (sub) and 101 (sra); any other funct7 other than 0000000 is illegal.
REQ-014 For I-ALU (0010011), the ALU operation SHALL decode from funct3; funct3 001 requires funct7=0000000 and 101 requires funct7 0000000 (srl) or 0100000 (sra); other shift funct7 values are illegal.
REQ-015 Load (0000011), store (0100011), jalr (1100111) and auipc (0010111) SHALL use add; branch (1100011) SHALL use add with sel_opr_a=1, imm_type=B; lui (0110111) SHALL use pass-B; jal (1101111) SHALL use add with sel_opr_a=1, imm_type=J.
REQ-016 Any other opcode, and any other illegal funct encoding, SHALL be illegal.
REQ-017 In FETCH, im_req SHALL be held at 1 until the cycle im_ack=1; in that cycle ir_en=1 for exactly one cycle and the next state is DECODE.
REQ-018 DECODE SHALL last one cycle: illegal goes to TRAP with illegal set; any other instruction goes to EXECUTE.
REQ-019 The mux, imm_type and aluop outputs SHALL be valid from DECODE through the last cycle of the instruction; rf_en, dm_req, pc_en and ir_en SHALL be 0 except where stated.
REQ-020 EXECUTE SHALL last one cycle: load/store go to MEM; branch goes to FETCH with pc_en=1 and sel_pc=br_taken; all others go to WB.
REQ-021 In MEM, dm_req SHALL be held at 1 until dm_ack; dm_we=1 only for store; on ack a load goes to WB, and a store goes to FETCH with pc_en=1, sel_pc=0.
REQ-022 WB SHALL last one cycle with pc_en=1 and rf_en=1 (rf_en=0 if RD_X0_GUARD=1 and rd=0).
REQ-023 In WB, sel_wb SHALL be 01 for load and 10 for jal/jalr, else 00; sel_pc SHALL be 1 for jal/jalr, else 0.
REQ-024 In FETCH and MEM, the wait counter SHALL increment each cycle without ack and clear on ack or state change; if the count reaches the limit without ack, next state is TRAP with bus_err set and the request deasserted.
REQ-025 An ack in the same cycle the counter reaches the limit SHALL win: normal transition, no bus_err.
REQ-026 TRAP SHALL be absorbing, with all strobes and requests 0, until reset; illegal and bus_err SHALL be sticky.
REQ-027 im_ack outside FETCH and dm_ack outside MEM SHALL be ignored.

Reset
REQ-028 When rst_n=0 at a rising clk edge, the next state SHALL be FETCH with the counter, illegal and bus_err cleared; all outputs SHALL be 0 except state=000 and im_req, which asserts the cycle after reset deasserts.
REQ-029 Reset SHALL take priority over every transition, including mid-MEM and in TRAP; an outstanding request SHALL drop in the cycle after the reset edge.

Verification
REQ-030 add x3,x1,x2 (0x002081B3), im_ack after 2 cycles -> FETCH(3 cycles), DECODE, EXECUTE aluop=0000, WB rf_en=1 sel_wb=00 pc_en=1; 6 cycles total.
REQ-031 lw x5,8(x1) (0x0080A283), dm_ack after 3 cycles -> MEM dm_req=1 for 4 cycles with dm_we=0, then WB sel_wb=01 rf_en=1.
REQ-032 beq taken (0x00208463, br_taken=1) -> EXECUTE pc_en=1 sel_pc=1, next FETCH, rf_en never 1; repeat with br_taken=0 -> sel_pc=0.
REQ-033 Opcode 0x7F, or instr 0x4020C1B3 (funct7 0100000 with funct3 100) -> DECODE then TRAP, illegal=1; state stays 111 with im_ack pulses until rst_n=0.
REQ-034 TIMEOUT_W=4, no im_ack -> im_req high for 15 cycles then TRAP, bus_err=1; second run with im_ack on the 15th cycle -> DECODE, bus_err=0.
REQ-035 addi x0,x0,1 (0x00100013) with RD_X0_GUARD=1 -> WB rf_en=0 pc_en=1; rst_n=0 during MEM -> FETCH next cycle, dm_req=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and decodes
// the instruction-register contents into datapath mux selects and an ALU op.
// Memory waits are bounded by a timeout counter. Illegal instructions and bus
// timeouts land in an absorbing TRAP state that only reset leaves.
module mc_controller #(
    parameter int TIMEOUT_W   = 4,
    parameter bit RD_X0_GUARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        im_ack,
    input  logic        dm_ack,
    input  logic        br_taken,
    output logic        im_req,
    output logic        ir_en,
    output logic        pc_en,
    output logic        dm_req,
    output logic        dm_we,
    output logic        rf_en,
    output logic        sel_opr_a,
    output logic        sel_opr_b,
    output logic        sel_pc,
    output logic [1:0]  sel_wb,
    output logic [2:0]  imm_type,
    output logic [3:0]  aluop,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_DECODE  = 3'b001,
        S_EXECUTE = 3'b010,
        S_MEM     = 3'b011,
        S_WB      = 3'b100,
        S_TRAP    = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP
    } kind_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                           ALU_SLT  = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                           ALU_SRL  = 4'b0110, ALU_SRA = 4'b0111, ALU_OR = 4'b1000,
                           ALU_AND  = 4'b1001, ALU_PASSB = 4'b1010;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111,
                           OP_JAL = 7'b1101111, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

    // Last waiting cycle: if no ack arrives here the count would hit 2^W-1.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register-source and immediate fields belong to the datapath only.
    assign unused_instr_bits = ^instr[24:15];

    state_t               state_q;
    logic [TIMEOUT_W-1:0] wait_cnt_q;
    logic                 illegal_q;
    logic                 bus_err_q;
    logic                 run_q;     // low for the first cycle after reset

    logic [3:0] dec_aluop;
    logic       dec_opr_a, dec_opr_b, dec_illegal;
    logic [2:0] dec_imm;
    logic [1:0] dec_wb;
    kind_t      dec_kind;

    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Instruction decode: ALU op, operand/immediate/writeback selects, legality.
    always_comb begin
        dec_aluop   = ALU_ADD;
        dec_opr_a   = 1'b0;
        dec_opr_b   = 1'b0;
        dec_imm     = 3'b000;
        dec_wb      = 2'b00;
        dec_illegal = 1'b0;
        dec_kind    = K_ALU;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE)                        dec_aluop = alu_base(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) dec_aluop = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) dec_aluop = ALU_SRA;
                else                                           dec_illegal = 1'b1;
            end
            OP_I: begin
                dec_opr_b = 1'b1;
                dec_aluop = alu_base(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) dec_illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec_aluop   = ALU_SRA;
                    else if (funct7 != F7_BASE) dec_illegal = 1'b1;
                end
            end
            OP_LOAD:   begin dec_opr_b = 1'b1; dec_wb = 2'b01; dec_kind = K_LOAD; end
            OP_STORE:  begin dec_opr_b = 1'b1; dec_imm = 3'b001; dec_kind = K_STORE; end
            OP_BRANCH: begin dec_opr_a = 1'b1; dec_opr_b = 1'b1; dec_imm = 3'b010; dec_kind = K_BRANCH; end
            OP_JALR:   begin dec_opr_b = 1'b1; dec_wb = 2'b10; dec_kind = K_JUMP; end
            OP_JAL:    begin dec_opr_a = 1'b1; dec_opr_b = 1'b1; dec_imm = 3'b100; dec_wb = 2'b10; dec_kind = K_JUMP; end
            OP_AUIPC:  begin dec_opr_a = 1'b1; dec_opr_b = 1'b1; dec_imm = 3'b011; end
            OP_LUI:    begin dec_opr_b = 1'b1; dec_imm = 3'b011; dec_aluop = ALU_PASSB; end
            default:   dec_illegal = 1'b1;
        endcase
    end

    // Sequencer: state, bus-wait counter and sticky error flags; reset wins over all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_FETCH: if (run_q) begin
                    if (im_ack) begin
                        state_q    <= S_DECODE;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= S_TRAP;
                        bus_err_q  <= 1'b1;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (dec_kind == K_LOAD || dec_kind == K_STORE) state_q <= S_MEM;
                    else if (dec_kind == K_BRANCH)                 state_q <= S_FETCH;
                    else                                           state_q <= S_WB;
                end
                S_MEM: begin
                    if (dm_ack) begin
                        state_q    <= (dec_kind == K_LOAD) ? S_WB : S_FETCH;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= S_TRAP;
                        bus_err_q  <= 1'b1;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_ONE;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    // Strobes follow the registered state; acks and br_taken act in the same cycle.
    always_comb begin
        im_req    = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_en     = 1'b0;
        sel_opr_a = 1'b0;
        sel_opr_b = 1'b0;
        sel_pc    = 1'b0;
        sel_wb    = 2'b00;
        imm_type  = 3'b000;
        aluop     = 4'b0000;
        if (run_q && state_q != S_FETCH && state_q != S_TRAP && !dec_illegal) begin
            sel_opr_a = dec_opr_a;
            sel_opr_b = dec_opr_b;
            sel_wb    = dec_wb;
            imm_type  = dec_imm;
            aluop     = dec_aluop;
        end
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    im_req = 1'b1;
                    ir_en  = im_ack;
                end
                S_EXECUTE: if (dec_kind == K_BRANCH) begin
                    pc_en  = 1'b1;
                    sel_pc = br_taken;
                end
                S_MEM: begin
                    dm_req = 1'b1;
                    dm_we  = (dec_kind == K_STORE);
                    pc_en  = dm_ack && (dec_kind == K_STORE);
                end
                S_WB: begin
                    pc_en  = 1'b1;
                    rf_en  = !(RD_X0_GUARD && rd == 5'd0);
                    sel_pc = (dec_kind == K_JUMP);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is walked phase by phase
// and every cycle's full output vector is compared with the value predicted
// from the decode rules and phase sequence kept here.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        im_ack = 1'b0, dm_ack = 1'b0, br_taken = 1'b0;
    logic        im_req, ir_en, pc_en, dm_req, dm_we, rf_en;
    logic        sel_opr_a, sel_opr_b, sel_pc, illegal, bus_err;
    logic [1:0]  sel_wb;
    logic [2:0]  imm_type, state;
    logic [3:0]  aluop;

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT_W(4), .RD_X0_GUARD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .im_ack(im_ack), .dm_ack(dm_ack),
        .br_taken(br_taken), .im_req(im_req), .ir_en(ir_en), .pc_en(pc_en),
        .dm_req(dm_req), .dm_we(dm_we), .rf_en(rf_en), .sel_opr_a(sel_opr_a),
        .sel_opr_b(sel_opr_b), .sel_pc(sel_pc), .sel_wb(sel_wb), .imm_type(imm_type),
        .aluop(aluop), .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    localparam int LIMIT = 15;  // 2^4-1 cycles of waiting before a bus timeout
    localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BR = 3'd3, K_JMP = 3'd4;
    localparam logic [2:0] ST_F = 3'b000, ST_D = 3'b001, ST_E = 3'b010, ST_M = 3'b011,
                           ST_W = 3'b100, ST_T = 3'b111;

    typedef struct packed {
        logic       legal;
        logic [2:0] kind;
        logic [3:0] alu;
        logic       a;
        logic       b;
        logic [2:0] imm;
        logic [1:0] wb;
    } dec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    logic exp_ill = 1'b0, exp_be = 1'b0;

    wire [22:0] outs = {im_req, ir_en, pc_en, dm_req, dm_we, rf_en, sel_opr_a, sel_opr_b,
                        sel_pc, sel_wb, imm_type, aluop, state, illegal, bus_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d: got %h expected %h", tag, n_txn, got, exp);
        end
    endtask

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    // Reference decode written straight from the instruction-set rules.
    function automatic dec_t ref_dec(input logic [31:0] ins);
        dec_t d;
        logic [3:0] base [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        d = '0;
        d.legal = 1'b1;
        d.kind  = K_ALU;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) d.alu = base[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd7;
                else d.legal = 1'b0;
            end
            7'b0010011: begin
                d.b = 1'b1; d.alu = base[f3];
                if (f3 == 3'd1 && f7 != 7'h00) d.legal = 1'b0;
                if (f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd7;
                if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) d.legal = 1'b0;
            end
            7'b0000011: begin d.b = 1'b1; d.wb = 2'd1; d.kind = K_LOAD; end
            7'b0100011: begin d.b = 1'b1; d.imm = 3'd1; d.kind = K_STORE; end
            7'b1100011: begin d.a = 1'b1; d.b = 1'b1; d.imm = 3'd2; d.kind = K_BR; end
            7'b1100111: begin d.b = 1'b1; d.wb = 2'd2; d.kind = K_JMP; end
            7'b1101111: begin d.a = 1'b1; d.b = 1'b1; d.imm = 3'd4; d.wb = 2'd2; d.kind = K_JMP; end
            7'b0010111: begin d.a = 1'b1; d.b = 1'b1; d.imm = 3'd3; end
            7'b0110111: begin d.b = 1'b1; d.imm = 3'd3; d.alu = 4'd10; end
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [22:0] pack(input logic [2:0] st, input logic req, input logic iren,
                                         input logic pce, input logic dreq, input logic dwe,
                                         input logic rfe, input logic spc, input logic use_dec,
                                         input dec_t d);
        dec_t z;
        z = use_dec ? d : '0;
        return {req, iren, pce, dreq, dwe, rfe, z.a, z.b, spc, z.wb, z.imm, z.alu, st, exp_ill, exp_be};
    endfunction

    task automatic cyc(input string tag, input logic [22:0] exp);
        @(negedge clk);
        check(tag, {9'd0, outs}, {9'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        im_ack = rbit(); dm_ack = rbit(); br_taken = rbit();
    endtask

    task automatic reset_tail();
        im_ack = 1'b0; dm_ack = 1'b0;
        cyc("reset_hold", pack(ST_F, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        rst_n = 1'b1;
        cyc("reset_release", pack(ST_F, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_ill = 1'b0; exp_be = 1'b0;
        reset_tail();
    endtask

    task automatic trap_hold(input string tag);
        for (int i = 0; i < 4; i++) begin
            noise(); instr = $urandom;
            cyc(tag, pack(ST_T, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        end
        do_reset();
    endtask

    // One instruction: fw/mw = cycles before the fetch/data ack (>=LIMIT means none),
    // rst_mem = MEM wait cycle at which reset is asserted (-1 for none).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic br, input int rst_mem);
        dec_t d;
        logic ack, done, st;
        d = ref_dec(ins);
        n_txn++;
        $display("txn %0d instr=%h fetch_wait=%0d mem_wait=%0d br=%0d legal=%0d",
                 n_txn, ins, fw, mw, br, d.legal);
        done = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            ack = (k == fw);
            im_ack = ack; dm_ack = rbit(); br_taken = rbit(); instr = $urandom;
            cyc("fetch", pack(ST_F, 1, ack, 0, 0, 0, 0, 0, 0, d));
            if (ack) begin done = 1'b1; break; end
        end
        if (!done) begin exp_be = 1'b1; trap_hold("fetch_timeout_trap"); return; end
        instr = ins; noise();
        cyc("decode", pack(ST_D, 0, 0, 0, 0, 0, 0, 0, d.legal, d));
        if (!d.legal) begin exp_ill = 1'b1; trap_hold("illegal_trap"); return; end
        noise(); br_taken = br;
        if (d.kind == K_BR) begin
            cyc("exec_branch", pack(ST_E, 0, 0, 1, 0, 0, 0, br, 1, d));
            return;
        end
        cyc("execute", pack(ST_E, 0, 0, 0, 0, 0, 0, 0, 1, d));
        if (d.kind == K_LOAD || d.kind == K_STORE) begin
            st = (d.kind == K_STORE);
            done = 1'b0;
            for (int k = 0; k < LIMIT; k++) begin
                ack = (k == mw);
                dm_ack = ack; im_ack = rbit(); br_taken = rbit();
                if (k == rst_mem) begin
                    rst_n = 1'b0; dm_ack = 1'b0;
                    cyc("mem_at_reset", pack(ST_M, 0, 0, 0, 1, st, 0, 0, 1, d));
                    exp_ill = 1'b0; exp_be = 1'b0;
                    reset_tail();
                    return;
                end
                cyc("mem", pack(ST_M, 0, 0, ack && st, 1, st, 0, 0, 1, d));
                if (ack) begin done = 1'b1; break; end
            end
            if (!done) begin exp_be = 1'b1; trap_hold("mem_timeout_trap"); return; end
            if (st) return;
        end
        noise();
        cyc("wb", pack(ST_W, 0, 0, 1, 0, 0, ins[11:7] != 5'd0, d.kind == K_JMP, 1, d));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [31:0] r;
        int idx, f7sel;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111};
        r = $urandom;
        idx = int'($urandom_range(9));
        if (idx < 9) r[6:0] = ops[idx];
        f7sel = int'($urandom_range(3));
        if (f7sel < 2) r[31:25] = 7'h00;
        else if (f7sel == 2) r[31:25] = 7'h20;
        if (rbit() && rbit()) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        do_reset();
        run_instr(32'h002081B3, 2, 0, 1'b0, -1);   // add x3,x1,x2
        run_instr(32'h0080A283, 0, 3, 1'b0, -1);   // lw x5,8(x1)
        run_instr(32'h00208463, 1, 0, 1'b1, -1);   // beq taken
        run_instr(32'h00208463, 0, 0, 1'b0, -1);   // beq not taken
        run_instr(32'h0000007F, 0, 0, 1'b0, -1);   // unknown opcode
        run_instr(32'h4020C1B3, 0, 0, 1'b0, -1);   // funct7 alt with xor
        run_instr(32'h002081B3, LIMIT, 0, 1'b0, -1); // no fetch ack at all
        run_instr(32'h002081B3, LIMIT - 1, 0, 1'b0, -1); // ack on the last cycle
        run_instr(32'h00100013, 0, 0, 1'b0, -1);   // addi x0,x0,1
        run_instr(32'h0080A283, 0, 20, 1'b0, 2);   // reset during MEM
        run_instr(32'h0020A423, 1, 2, 1'b0, -1);   // sw x2,8(x1)
        run_instr(32'h0080A283, 0, LIMIT, 1'b0, -1); // no data ack
        run_instr(32'h0020A423, 0, LIMIT - 1, 1'b0, -1); // data ack on last cycle
        run_instr(32'h008000EF, 0, 0, 1'b0, -1);   // jal x1
        run_instr(32'h000080E7, 0, 0, 1'b0, -1);   // jalr x1
        run_instr(32'h123452B7, 0, 0, 1'b0, -1);   // lui x5
        run_instr(32'h4030D293, 0, 0, 1'b0, -1);   // srai
        run_instr(32'h02109293, 0, 0, 1'b0, -1);   // slli with bad funct7
        for (int t = 0; t < 60; t++) begin
            run_instr(rand_instr(),
                      (t % 13 == 5) ? LIMIT - 1 : int'($urandom_range(3)),
                      (t % 11 == 4) ? LIMIT - 1 : int'($urandom_range(3)),
                      rbit(), (t % 17 == 9) ? 1 : -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
